// File: rtl/expr_pkg.sv
// expr_pkg: ASCII constants, operator codes, FSM states and token type for expr_char_gen
package expr_pkg;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  typedef enum logic [1:0] {EXP_NUM, EXP_OP, FLUSH} state_t;
  typedef struct packed {
    logic op;
    logic [3:0] val;
    logic last;
  } tok_t;
endpackage

// File: rtl/tok_fifo.sv
// tok_fifo: sync FIFO (clk, async clr_n, push/din in, pop in, head/full/empty out), combinational head
module tok_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == FULL_CNT;
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/expr_char_gen.sv
// expr_char_gen: token stream (tok_*) -> ASCII char stream (chr*) for digit(op digit)* with sticky err, async clr_n
module expr_char_gen
  import expr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic       tok_op,
  input  logic [3:0] tok_val,
  input  logic       tok_last,
  output logic [7:0] chr,
  output logic       chr_valid,
  input  logic       chr_ready,
  output logic       chr_last,
  output logic       err
);
  tok_t head;
  state_t state, nxt;
  logic full, empty, free, pop, load, ld_last, bad;
  logic [7:0] ld_chr;
  assign tok_ready = !full;
  assign free = !chr_valid || chr_ready;
  assign pop = free && !empty;
  tok_fifo #(.DEPTH(DEPTH), .W($bits(tok_t))) u_fifo (
    .clk(clk),
    .clr_n(clr_n),
    .push(tok_valid && tok_ready),
    .pop(pop),
    .din({tok_op, tok_val, tok_last}),
    .head(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    nxt = state;
    load = 1'b0;
    bad = 1'b0;
    ld_chr = CH_ZERO + {4'd0, head.val};
    ld_last = head.last;
    if (pop) begin
      if (state == FLUSH) nxt = head.last ? EXP_NUM : FLUSH;
      else if (state == EXP_NUM) begin
        bad = head.op || head.val > 4'd9;
        load = !bad;
        nxt = bad ? FLUSH : head.last ? EXP_NUM : EXP_OP;
      end else begin
        bad = !head.op || head.last || !(head.val == OP_ADD || head.val == OP_MUL);
        load = !bad;
        ld_chr = head.val == OP_MUL ? CH_MUL : CH_PLUS;
        ld_last = 1'b0;
        nxt = bad ? FLUSH : EXP_NUM;
      end
    end
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= EXP_NUM;
      chr <= '0;
      chr_valid <= 1'b0;
      chr_last <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      err <= err | bad;
      if (free) begin
        chr_valid <= load;
        chr_last <= load && ld_last;
        if (load) chr <= ld_chr;
      end
    end
endmodule

// File: tb/tb_expr_char_gen.sv
// tb_expr_char_gen: table-driven and directed-sequence checks for expr_char_gen
module tb_expr_char_gen;
  import expr_pkg::*;
  logic clk = 1'b0, clr_n = 1'b1, tok_valid = 1'b0, tok_op = 1'b0, tok_last = 1'b0, chr_ready = 1'b0;
  logic [3:0] tok_val = '0;
  logic tok_ready, chr_valid, chr_last, err;
  logic [7:0] chr;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {
    logic [7:0] c;
    logic l;
    int cyc;
  } ev_t;
  ev_t got[$];
  typedef struct {
    int n;
    tok_t t0;
    tok_t t1;
    int nchr;
    logic [7:0] c;
    logic l;
    logic e;
  } vec_t;
  vec_t vecs[7];
  expr_char_gen #(.DEPTH(4)) dut (
    .clk(clk), .clr_n(clr_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_op(tok_op), .tok_val(tok_val), .tok_last(tok_last),
    .chr(chr), .chr_valid(chr_valid), .chr_ready(chr_ready), .chr_last(chr_last), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (clr_n && chr_valid && chr_ready) got.push_back('{chr, chr_last, cyc});
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  task automatic send(input tok_t t, output bit acc);
    tok_valid = 1'b1;
    {tok_op, tok_val, tok_last} = t;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = tok_ready;
      tick();
    end
  endtask
  task automatic send_ok(input string name, input tok_t t);
    bit acc;
    send(t, acc);
    chk(name, 32'(acc), 32'd1);
  endtask
  task automatic do_reset();
    tok_valid = 1'b0;
    chr_ready = 1'b0;
    #2 clr_n = 1'b0;
    tick(2);
    clr_n = 1'b1;
    got.delete();
  endtask
  task automatic chk_q(input string name, input string s, input logic fl, input bit cons);
    chk({name, "_n"}, 32'(got.size()), 32'(s.len()));
    for (int i = 0; i < s.len() && i < got.size(); i++) begin
      chk($sformatf("%s_c%0d", name, i), 32'(got[i].c), 32'(s[i]));
      chk($sformatf("%s_l%0d", name, i), 32'(got[i].l), 32'(i == s.len() - 1 ? fl : 1'b0));
      if (cons && i > 0) chk($sformatf("%s_cyc%0d", name, i), 32'(got[i].cyc - got[0].cyc), 32'(i));
    end
  endtask
  function automatic tok_t dg(input logic [3:0] v, input logic l);
    return '{op: 1'b0, val: v, last: l};
  endfunction
  function automatic tok_t op(input logic [3:0] v, input logic l);
    return '{op: 1'b1, val: v, last: l};
  endfunction
  initial begin
    bit acc;
    int n_acc;
    vecs[0] = '{1, dg(5, 1), dg(0, 0), 1, 8'h35, 1'b1, 1'b0};
    vecs[1] = '{1, dg(0, 0), dg(0, 0), 1, 8'h30, 1'b0, 1'b0};
    vecs[2] = '{1, dg(9, 1), dg(0, 0), 1, 8'h39, 1'b1, 1'b0};
    vecs[3] = '{1, dg(10, 1), dg(0, 0), 0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{2, dg(3, 0), op(2, 0), 1, 8'h33, 1'b0, 1'b1};
    vecs[5] = '{2, dg(3, 0), op(0, 1), 1, 8'h33, 1'b0, 1'b1};
    vecs[6] = '{1, op(0, 0), dg(0, 0), 0, 8'h00, 1'b0, 1'b1};
    #2 clr_n = 1'b0;
    #3;
    chk("rst_valid", 32'(chr_valid), 0);
    chk("rst_chr", 32'(chr), 0);
    chk("rst_last", 32'(chr_last), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(tok_ready), 1);
    do_reset();
    foreach (vecs[k]) begin
      do_reset();
      chr_ready = 1'b1;
      send_ok($sformatf("v%0d_acc0", k), vecs[k].t0);
      if (vecs[k].n > 1) send_ok($sformatf("v%0d_acc1", k), vecs[k].t1);
      tok_valid = 1'b0;
      tick(6);
      chk($sformatf("v%0d_nchr", k), 32'(got.size()), 32'(vecs[k].nchr));
      if (vecs[k].nchr > 0 && got.size() > 0) begin
        chk($sformatf("v%0d_chr", k), 32'(got[0].c), 32'(vecs[k].c));
        chk($sformatf("v%0d_last", k), 32'(got[0].l), 32'(vecs[k].l));
      end
      chk($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].e));
    end
    do_reset();
    chr_ready = 1'b1;
    send_ok("s1_a", dg(6, 0));
    send_ok("s1_b", op(0, 0));
    send_ok("s1_c", dg(9, 0));
    send_ok("s1_d", op(0, 0));
    send_ok("s1_e", dg(4, 1));
    tok_valid = 1'b0;
    tick(6);
    chk_q("s1", "6+9+4", 1'b1, 1'b1);
    chk("s1_err", 32'(err), 0);
    chk("s1_idle", 32'(chr_valid), 0);
    do_reset();
    send_ok("s2_a", dg(6, 0));
    send_ok("s2_b", op(1, 0));
    send_ok("s2_c", dg(6, 1));
    tok_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s2_hold_v%0d", i), 32'(chr_valid), 1);
      chk($sformatf("s2_hold_c%0d", i), 32'(chr), 32'h36);
      tick();
    end
    chr_ready = 1'b1;
    tick(6);
    chk_q("s2", "6*6", 1'b1, 1'b1);
    do_reset();
    n_acc = 0;
    send(dg(1, 0), acc); n_acc += int'(acc);
    send(op(0, 0), acc); n_acc += int'(acc);
    send(dg(2, 0), acc); n_acc += int'(acc);
    send(op(1, 0), acc); n_acc += int'(acc);
    send(dg(3, 1), acc); n_acc += int'(acc);
    send(dg(4, 1), acc); n_acc += int'(acc);
    tok_valid = 1'b0;
    chk("s3_accepted", 32'(n_acc), 5);
    chk("s3_full", 32'(tok_ready), 0);
    chk("s3_head", 32'(chr), 32'h31);
    chr_ready = 1'b1;
    tick(8);
    chk_q("s3", "1+2*3", 1'b1, 1'b1);
    chk("s3_ready", 32'(tok_ready), 1);
    do_reset();
    chr_ready = 1'b1;
    send_ok("s4_a", dg(6, 0));
    send_ok("s4_b", dg(9, 0));
    send_ok("s4_c", dg(1, 0));
    send_ok("s4_d", dg(2, 1));
    send_ok("s4_e", dg(3, 1));
    tok_valid = 1'b0;
    tick(6);
    chk_q("s4", "63", 1'b1, 1'b0);
    chk("s4_err", 32'(err), 1);
    chr_ready = 1'b0;
    got.delete();
    send_ok("s5_a", dg(1, 0));
    send_ok("s5_b", op(0, 0));
    send_ok("s5_c", dg(2, 0));
    send_ok("s5_d", op(0, 0));
    tok_valid = 1'b0;
    tick();
    chk("s5_pre_v", 32'(chr_valid), 1);
    chk("s5_pre_err", 32'(err), 1);
    #2 clr_n = 1'b0;
    #1;
    chk("s5_rst_v", 32'(chr_valid), 0);
    chk("s5_rst_c", 32'(chr), 0);
    chk("s5_rst_err", 32'(err), 0);
    chk("s5_rst_rdy", 32'(tok_ready), 1);
    tick(2);
    clr_n = 1'b1;
    got.delete();
    chr_ready = 1'b1;
    send_ok("s5_e", dg(7, 1));
    tok_valid = 1'b0;
    tick(6);
    chk_q("s5", "7", 1'b1, 1'b0);
    chk("s5_err", 32'(err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/expr_char_gen.md
# expr_char_gen

Expression character generator: the transmit-side counterpart of the expression string recognizer. It accepts operand/operator tokens over a valid/ready handshake, buffers them in a small FIFO, checks the `digit (op digit)*` grammar, and emits one ASCII character per cycle on a valid/ready character stream. The emitted characters are exactly the stream the recognizer consumes: '0'–'9', '+', '*'. It sits between the token producer and the recognizer's `in` bus.

## Interface
- `DEPTH`, default 4: token FIFO depth; power of 2, at least 2.
- `clk`  in  1: rising-edge clock.
- `clr_n`  in  1: reset, asynchronous, active-low.
- `tok_valid`  in  1: token offered.
- `tok_ready`  out  1: FIFO not full. A token is accepted when `tok_valid && tok_ready`.
- `tok_op`  in  1: 1 = operator, 0 = digit.
- `tok_val`  in  4: digit value 0–9, or operator code (0 = '+', 1 = '*', others illegal).
- `tok_last`  in  1: final token of the expression.
- `chr`  out  8: ASCII character.
- `chr_valid`  out  1: `chr` valid.
- `chr_ready`  in  1: consumer accepts `chr`.
- `chr_last`  out  1: `chr` is the final character of the expression.
- `err`  out  1: sticky grammar-error flag.

## Operation
- Tokens enter the FIFO as `{tok_op, tok_val, tok_last}`.
- The output register is "free" when `!chr_valid || chr_ready`. When the register is free and the FIFO is not empty, the head token is popped and evaluated by the FSM.
- FSM states and transitions:
  - EXP_NUM: the head must be a digit with `tok_val` ≤ 9.
    - Load `chr = 8'h30 + tok_val` and `chr_last = tok_last`.
    - Next state is EXP_NUM if `tok_last`, otherwise EXP_OP.
  - EXP_OP: the head must be an operator with code 0 or 1 and `tok_last = 0`.
    - Load 8'h2B for '+' or 8'h2A for '*', with `chr_last = 0`.
    - Next state is EXP_NUM.
  - Any violation in EXP_NUM or EXP_OP: the token is discarded, nothing is loaded, `err` is set to 1, and the next state is FLUSH.
  - FLUSH: pop and discard one token per cycle, with no output. Popping a token with `tok_last = 1` returns the FSM to EXP_NUM. Characters already emitted for the broken expression stay emitted, and no `chr_last` is produced for it.
- `err` is cleared only by reset.
- If nothing is popped while `chr_ready` is 1, `chr_valid` falls to 0.

## Timing
- Reset values:
  - `chr` = 0, `chr_valid` = 0, `chr_last` = 0, `err` = 0.
  - `tok_ready` = 1, FIFO empty with pointers 0, FSM in EXP_NUM.
  - All of these take effect immediately on the falling edge of `clr_n`, independent of `clk`.
- Latency: a token accepted at edge E into an empty FIFO, with the output register free, appears on `chr`/`chr_valid` after edge E+1.
- Throughput: 1 character per cycle while `chr_ready = 1` and the FIFO is non-empty.
- `chr`, `chr_last` and `chr_valid` are registered. They stay stable while `chr_valid && !chr_ready`.
- `tok_ready = !full`, derived from the registered occupancy count only. When the FIFO is full, no token is accepted in that cycle, even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO: the count is unchanged.
- Pointers wrap modulo DEPTH. The count is `$clog2(DEPTH)+1` bits wide.
- Reset asserted mid-stream drops all buffered and in-flight tokens. The first token after `clr_n` rises is treated as the start of a new expression.

## Structure
- Package `expr_pkg` holds:
  - ASCII constants `CH_ZERO`, `CH_PLUS`, `CH_MUL`.
  - Operator codes `OP_ADD = 0`, `OP_MUL = 1`.
  - FSM state enum `{EXP_NUM, EXP_OP, FLUSH}`.
  - Packed token struct type.
- One sub-module, `tok_fifo`: a parameterised synchronous FIFO with push/pop, full/empty, the same `clk`/`clr_n`, and a combinational head output.
- The FSM and output register live in `expr_char_gen`.

## Test plan
- Tokens 6, +, 9, +, 4(last) with `chr_ready = 1` -> `chr` = "6", "+", "9", "+", "4" on consecutive cycles; `chr_last` only on "4"; `err = 0`.
- Tokens 6, *, 6(last), with `chr_ready` held low 3 cycles after "6" appears -> "6" held stable for those 3 cycles, then "*", "6" follow with no loss or reordering.
- `chr_ready = 0`, offer 6 tokens with DEPTH = 4 -> exactly 5 tokens accepted (4 in the FIFO, 1 in the output register), then `tok_ready = 0`. Raising `chr_ready` drains all 5 in order.
- Tokens 6, 9, 1, 2(last), 3(last) -> "6" emitted; `err` rises when 9 is popped; 1 and 2 are flushed; then "3" with `chr_last = 1`; `err` stays 1.
- Illegal inputs each flag `err` with no character emitted:
  - digit value 10;
  - operator code 2;
  - `+` carrying `tok_last`;
  - operator as the first token.
- With the FIFO holding 3 tokens, pull `clr_n` low between clock edges -> `chr_valid`, `chr` and `err` go to 0 immediately and `tok_ready = 1`. After release, 7(last) yields "7" with `chr_last = 1`.
